// File: rtl/led_period_meter_pkg.sv
// rtl/led_period_meter_pkg.sv - shared FSM state type and default parameters for the LED period meter.
package led_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TMO     = 2'd2
  } meter_state_e;

  localparam int DEF_CNT_W       = 25;
  localparam int DEF_TIMEOUT_MAX = 24_999_999;
  localparam int DEF_LOCK_TOL    = 1;

endpackage

// File: rtl/led_period_meter_if.sv
// rtl/led_period_meter_if.sv - measurement result bundle produced by the period meter.
interface led_period_meter_if #(
  parameter int CNT_W = led_meter_pkg::DEF_CNT_W
);

  logic [CNT_W-1:0] half_period;
  logic             level_out;
  logic             meas_valid;
  logic             timeout;
  logic             locked;

  modport master (
    output half_period,
    output level_out,
    output meas_valid,
    output timeout,
    output locked
  );

  modport slave (
    input half_period,
    input level_out,
    input meas_valid,
    input timeout,
    input locked
  );

endinterface

// File: rtl/led_period_meter_sync_edge_det.sv
// rtl/led_period_meter_sync_edge_det.sv - 2-FF synchronizer plus a third stage for any-edge detection.
module sync_edge_det (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic din,
  output logic level,
  output logic edge_pulse
);

  logic stage1;
  logic stage2;
  logic stage3;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stage1 <= 1'b0;
      stage2 <= 1'b0;
      stage3 <= 1'b0;
    end else begin
      stage1 <= din;
      stage2 <= stage1;
      stage3 <= stage2;
    end
  end

  // stage3 still holds the pre-edge level during the edge cycle
  assign level      = stage3;
  assign edge_pulse = stage2 ^ stage3;

endmodule

// File: rtl/led_period_meter.sv
// rtl/led_period_meter.sv - measures each half period of a toggling input, with timeout and lock flags.
module led_period_meter
  import led_meter_pkg::*;
#(
  parameter int               CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(DEF_TIMEOUT_MAX),
  parameter logic [CNT_W-1:0] LOCK_TOL    = CNT_W'(DEF_LOCK_TOL)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  sig_in,
  led_period_meter_if.master    meas
);

  meter_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hp_q, hp_nxt;
  logic             lvl_q, lvl_nxt;
  logic             mv_q, mv_nxt;
  logic             tmo_q, tmo_nxt;
  logic             lock_q, lock_nxt;
  logic             have_prev, have_prev_nxt;

  logic             sync_level;
  logic             sync_edge;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   abs_diff;
  logic             within_tol;

  sync_edge_det u_sync (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .din        (sig_in),
    .level      (sync_level),
    .edge_pulse (sync_edge)
  );

  // one extra bit keeps the difference from wrapping before the sign test
  assign cnt_inc    = cnt + 1'b1;
  assign diff       = {1'b0, cnt_inc} - {1'b0, hp_q};
  assign abs_diff   = diff[CNT_W] ? ((CNT_W+1)'(0) - diff) : diff;
  assign within_tol = (abs_diff <= {1'b0, LOCK_TOL});

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hp_nxt        = hp_q;
    lvl_nxt       = lvl_q;
    mv_nxt        = 1'b0;
    tmo_nxt       = tmo_q;
    lock_nxt      = lock_q;
    have_prev_nxt = have_prev;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (sync_edge) begin
          state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // an edge on the timeout cycle still counts as a measurement
        if (sync_edge) begin
          hp_nxt        = cnt_inc;
          lvl_nxt       = sync_level;
          mv_nxt        = 1'b1;
          cnt_nxt       = '0;
          lock_nxt      = have_prev && within_tol;
          have_prev_nxt = 1'b1;
        end else if (cnt_inc == TIMEOUT_MAX) begin
          state_nxt     = ST_TMO;
          tmo_nxt       = 1'b1;
          lock_nxt      = 1'b0;
          have_prev_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_TMO: begin
        if (sync_edge) begin
          state_nxt = ST_MEASURE;
          tmo_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt       <= '0;
      hp_q      <= '0;
      lvl_q     <= 1'b0;
      mv_q      <= 1'b0;
      tmo_q     <= 1'b0;
      lock_q    <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      hp_q      <= hp_nxt;
      lvl_q     <= lvl_nxt;
      mv_q      <= mv_nxt;
      tmo_q     <= tmo_nxt;
      lock_q    <= lock_nxt;
      have_prev <= have_prev_nxt;
    end
  end

  assign meas.half_period = hp_q;
  assign meas.level_out   = lvl_q;
  assign meas.meas_valid  = mv_q;
  assign meas.timeout     = tmo_q;
  assign meas.locked      = lock_q;

endmodule

// File: tb/tb_led_period_meter.sv
// tb/tb_led_period_meter.sv - directed self-checking bench for led_period_meter.
module tb_led_period_meter;

  localparam int CNT_W = 25;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic sig_in  = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [CNT_W-1:0] q_hp[$];
  logic             q_lv[$];
  logic             q_lk[$];
  logic             tmo_seen = 1'b0;

  led_period_meter_if #(.CNT_W(CNT_W)) mif ();

  led_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_MAX (25'd100),
    .LOCK_TOL    (25'd1)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .sig_in  (sig_in),
    .meas    (mif)
  );

  always #10 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (mif.meas_valid === 1'b1) begin
      q_hp.push_back(mif.half_period);
      q_lv.push_back(mif.level_out);
      q_lk.push_back(mif.locked);
    end
    if (mif.timeout === 1'b1) tmo_seen = 1'b1;
  end

  task automatic apply_reset();
    sig_in  = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    q_hp.delete();
    q_lv.delete();
    q_lk.delete();
    tmo_seen = 1'b0;
  endtask

  task automatic toggle_after(input int n);
    repeat (n) @(posedge sys_clk);
    #1 sig_in = ~sig_in;
  endtask

  task automatic settle();
    repeat (6) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    sig_in  = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (mif.half_period !== '0) begin errors++; $display("FAIL reset_hp got %0d want 0", mif.half_period); end
    checks++; if (mif.level_out !== 1'b0) begin errors++; $display("FAIL reset_level got %b want 0", mif.level_out); end
    checks++; if (mif.meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mif.meas_valid); end
    checks++; if (mif.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", mif.timeout); end
    checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", mif.locked); end
    apply_reset();
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (q_hp.size() != 0) begin errors++; $display("FAIL idle_no_valid got %0d pulses want 0", q_hp.size()); end
  endtask

  task automatic test_symmetric();
    apply_reset();
    toggle_after(1);
    for (int i = 0; i < 5; i++) toggle_after(25);
    settle();
    checks++;
    if (q_hp.size() != 5) begin
      errors++; $display("FAIL sym_count got %0d want 5", q_hp.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (q_hp[i] !== 25) begin errors++; $display("FAIL sym_hp[%0d] got %0d want 25", i, q_hp[i]); end
        checks++; if (q_lv[i] !== ((i % 2) == 0)) begin errors++; $display("FAIL sym_level[%0d] got %b want %b", i, q_lv[i], (i % 2) == 0); end
        checks++; if (q_lk[i] !== (i != 0)) begin errors++; $display("FAIL sym_locked[%0d] got %b want %b", i, q_lk[i], i != 0); end
      end
    end
  endtask

  task automatic test_asymmetric();
    apply_reset();
    toggle_after(1);
    toggle_after(10);
    toggle_after(30);
    toggle_after(10);
    toggle_after(30);
    settle();
    checks++;
    if (q_hp.size() != 4) begin
      errors++; $display("FAIL asym_count got %0d want 4", q_hp.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (q_hp[i] !== ((i % 2) == 0 ? 10 : 30)) begin errors++; $display("FAIL asym_hp[%0d] got %0d want %0d", i, q_hp[i], (i % 2) == 0 ? 10 : 30); end
        checks++; if (q_lv[i] !== ((i % 2) == 0)) begin errors++; $display("FAIL asym_level[%0d] got %b want %b", i, q_lv[i], (i % 2) == 0); end
        checks++; if (q_lk[i] !== 1'b0) begin errors++; $display("FAIL asym_locked[%0d] got %b want 0", i, q_lk[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    toggle_after(1);
    toggle_after(25);
    toggle_after(25);
    // edge reaches the FSM 3 clocks after the toggle, so timeout lands on clock 103
    repeat (102) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (mif.timeout !== 1'b0) begin errors++; $display("FAIL tmo_early got %b want 0", mif.timeout); end
    checks++; if (mif.locked !== 1'b1) begin errors++; $display("FAIL tmo_prelock got %b want 1", mif.locked); end
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++; if (mif.timeout !== 1'b1) begin errors++; $display("FAIL tmo_assert got %b want 1", mif.timeout); end
    checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL tmo_unlock got %b want 0", mif.locked); end
    checks++; if (mif.half_period !== 25) begin errors++; $display("FAIL tmo_hp_kept got %0d want 25", mif.half_period); end
    toggle_after(47);
    settle();
    checks++; if (mif.timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b want 0", mif.timeout); end
    checks++; if (q_hp.size() != 2) begin errors++; $display("FAIL tmo_no_valid got %0d pulses want 2", q_hp.size()); end
    toggle_after(19);
    settle();
    checks++;
    if (q_hp.size() != 3) begin
      errors++; $display("FAIL tmo_resume_count got %0d want 3", q_hp.size());
    end else begin
      checks++; if (q_hp[2] !== 25) begin errors++; $display("FAIL tmo_resume_hp got %0d want 25", q_hp[2]); end
      checks++; if (q_lv[2] !== 1'b0) begin errors++; $display("FAIL tmo_resume_level got %b want 0", q_lv[2]); end
      checks++; if (q_lk[2] !== 1'b0) begin errors++; $display("FAIL tmo_resume_locked got %b want 0", q_lk[2]); end
    end
  endtask

  task automatic test_edge_at_timeout();
    apply_reset();
    toggle_after(1);
    toggle_after(100);
    settle();
    checks++;
    if (q_hp.size() != 1) begin
      errors++; $display("FAIL race_count got %0d want 1", q_hp.size());
    end else begin
      checks++; if (q_hp[0] !== 100) begin errors++; $display("FAIL race_hp got %0d want 100", q_hp[0]); end
      checks++; if (q_lv[0] !== 1'b1) begin errors++; $display("FAIL race_level got %b want 1", q_lv[0]); end
    end
    checks++; if (tmo_seen !== 1'b0) begin errors++; $display("FAIL race_timeout got %b want 0", tmo_seen); end
    toggle_after(95);
    settle();
    checks++; if (tmo_seen !== 1'b1) begin errors++; $display("FAIL late_timeout got %b want 1", tmo_seen); end
    checks++; if (q_hp.size() != 1) begin errors++; $display("FAIL late_no_valid got %0d pulses want 1", q_hp.size()); end
    checks++; if (mif.timeout !== 1'b0) begin errors++; $display("FAIL late_clear got %b want 0", mif.timeout); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    toggle_after(1);
    toggle_after(25);
    repeat (12) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    checks++; if (mif.half_period !== '0) begin errors++; $display("FAIL rst_mid_hp got %0d want 0", mif.half_period); end
    checks++; if ({mif.level_out, mif.meas_valid, mif.timeout, mif.locked} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_flags got %b want 0000", {mif.level_out, mif.meas_valid, mif.timeout, mif.locked});
    end
    q_hp.delete(); q_lv.delete(); q_lk.delete();
    toggle_after(12);
    settle();
    checks++; if (q_hp.size() != 0) begin errors++; $display("FAIL rst_mid_first got %0d pulses want 0", q_hp.size()); end
    toggle_after(19);
    settle();
    checks++;
    if (q_hp.size() != 1) begin
      errors++; $display("FAIL rst_mid_count got %0d want 1", q_hp.size());
    end else begin
      checks++; if (q_hp[0] !== 25) begin errors++; $display("FAIL rst_mid_meas got %0d want 25", q_hp[0]); end
      checks++; if (q_lv[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_level got %b want 1", q_lv[0]); end
    end
  endtask

  task automatic test_jitter();
    int gaps[4];
    logic exp_lk[4];
    gaps   = '{25, 26, 25, 28};
    exp_lk = '{1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    toggle_after(1);
    for (int i = 0; i < 4; i++) toggle_after(gaps[i]);
    settle();
    checks++;
    if (q_hp.size() != 4) begin
      errors++; $display("FAIL jit_count got %0d want 4", q_hp.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (q_hp[i] !== gaps[i]) begin errors++; $display("FAIL jit_hp[%0d] got %0d want %0d", i, q_hp[i], gaps[i]); end
        checks++; if (q_lk[i] !== exp_lk[i]) begin errors++; $display("FAIL jit_locked[%0d] got %b want %b", i, q_lk[i], exp_lk[i]); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_symmetric();
    test_asymmetric();
    test_timeout();
    test_edge_at_timeout();
    test_reset_mid();
    test_jitter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_period_meter.md
LED_PERIOD_METER -- requirements
Module: led_period_meter

Interface
REQ-001 Parameter CNT_W, default 25, width of the period counter and of the half_period output.
REQ-002 Parameter TIMEOUT_MAX, default 25'd24_999_999, the number of cycles with no edge after which the block declares timeout; legal range 2 .. 2^CNT_W-2.
REQ-003 Parameter LOCK_TOL, default 1, the maximum difference between consecutive half periods for locked to assert.
REQ-004 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 sys_rst  input  1  reset, synchronous, active-high.
REQ-006 sig_in  input  1  asynchronous toggling signal under measurement (e.g. LED drive from the counter block).
REQ-007 half_period  output  CNT_W  length, in sys_clk cycles, of the most recently completed level of sig_in.
REQ-008 level_out  output  1  level of sig_in during the interval reported in half_period.
REQ-009 meas_valid  output  1  one-cycle pulse; half_period and level_out updated in the same cycle.
REQ-010 timeout  output  1  high while no sig_in edge has arrived within TIMEOUT_MAX cycles.
REQ-011 locked  output  1  high while the last two reported half periods differ by at most LOCK_TOL.

Function
REQ-012 sig_in shall pass through a 2-FF synchronizer; a third register stage shall produce edge = stage2 XOR stage3, covering both rising and falling edges.
REQ-013 The FSM shall have states IDLE (no edge seen yet), MEASURE, and TMO.
REQ-014 IDLE: cnt held at 0; on edge -> MEASURE, cnt cleared to 0, no meas_valid.
REQ-015 MEASURE: cnt increments by 1 per cycle without edge; on edge -> half_period <= cnt+1, level_out <= stage3, meas_valid pulses for 1 cycle, cnt <= 0.
REQ-016 MEASURE: when cnt+1 reaches TIMEOUT_MAX without an edge that cycle -> TMO, timeout <= 1, locked <= 0, cnt frozen.
REQ-017 An edge in the same cycle as the timeout condition shall win: the cycle is treated as a normal measurement with half_period = TIMEOUT_MAX, and there is no transition to TMO.
REQ-018 TMO: on edge -> MEASURE, timeout <= 0, cnt <= 0, no meas_valid (the partial interval is discarded); half_period keeps its old value.
REQ-019 locked shall be evaluated on each meas_valid cycle: locked <= 1 if |new half_period - previous half_period| <= LOCK_TOL, else 0; the first measurement after IDLE or TMO has no previous value and sets locked <= 0.
REQ-020 Latency from a sig_in transition to meas_valid high shall be 3 sys_clk rising edges ±1 (synchronizer uncertainty).
REQ-021 All outputs shall be registered; there are no combinational paths from sig_in to any output.
REQ-022 Subtraction for the lock compare shall be done at CNT_W+1 bits to avoid wrap.

Reset
REQ-023 While sys_rst=1 at a clock edge: FSM -> IDLE, cnt=0, synchronizer stages=0, half_period=0, level_out=0, meas_valid=0, timeout=0, locked=0, stored previous period=0.
REQ-024 Reset asserted mid-measurement shall discard the interval in progress; the first edge after release behaves as from IDLE (no meas_valid).
REQ-025 Reset shall take priority over edge and timeout events in the same cycle.

Structure
REQ-026 Package led_meter_pkg shall hold the FSM state enumeration and the default CNT_W/TIMEOUT_MAX/LOCK_TOL constants.
REQ-027 Synchronizer plus edge detection shall be a sub-module sync_edge_det (ports sys_clk, sys_rst, din, level, edge), reusable for other button/LED inputs.
REQ-028 Target size: 120-400 lines of RTL total.

Verification (sys_clk 50 MHz, TIMEOUT_MAX=100 unless noted)
REQ-029 sig_in toggles every 25 cycles -> first edge gives no pulse; every subsequent meas_valid reports half_period=25 with level_out alternating; locked=1 from the third edge onward.
REQ-030 Asymmetric input, 10 cycles high / 30 low -> half_period alternates 10 (level_out=1) / 30 (level_out=0); locked stays 0.
REQ-031 sig_in held constant 150 cycles after an edge -> timeout=1 exactly 100 cycles after that edge's cnt clear, locked=0; next edge clears timeout with no meas_valid; the following edge gives a valid measurement.
REQ-032 Edge arriving exactly at the timeout cycle -> meas_valid with half_period=100, timeout stays 0.
REQ-033 sys_rst pulsed 1 cycle at cycle 12 of a 25-cycle interval -> all outputs 0 next cycle; the next edge produces no meas_valid; the one after reports 25.
REQ-034 Period jitter 25/26/25 with LOCK_TOL=1 -> locked=1; jump to 28 -> locked=0 on that meas_valid.
